// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The slave side is the loader. The master side is the byte source plus the memory.
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, im_we, im_addr, im_wdata, cpu_rst, busy, done, err
    );

    modport master (
        output start, in_valid, in_data,
        input  in_ready, im_we, im_addr, im_wdata, cpu_rst, busy, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a program into the instruction memory from a big-endian byte stream.
// The stream is a 32-bit word count followed by the words. The CPU is held in reset while loading.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_DONE, S_ERR} state_e;

    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

    state_e            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [ADDR_W:0]   word_idx_q, word_idx_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [23:0]       shift_q, shift_d;
    logic              in_ready_q, in_ready_d;
    logic              im_we_q, im_we_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [31:0]       im_wdata_q, im_wdata_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic [31:0]       word;
    logic [ADDR_W:0]   next_idx;

    assign accept   = bus.in_valid & in_ready_q;
    assign word     = {shift_q, bus.in_data};
    assign next_idx = word_idx_q + (ADDR_W+1)'(1);

    always_comb begin
        // NOTE: every _d gets a default before the case, so no path leaves a latch behind.
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        count_d    = count_q;
        shift_d    = shift_q;
        in_ready_d = in_ready_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        cpu_rst_d  = cpu_rst_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;

        unique case (state_q)
            S_HDR: begin
                if (accept) begin
                    shift_d    = word[23:0];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (word == 32'd0) begin
                            state_d    = S_DONE;
                            done_d     = 1'b1;
                            busy_d     = 1'b0;
                            in_ready_d = 1'b0;
                        end else if (word > DEPTH) begin
                            state_d    = S_ERR;
                            err_d      = 1'b1;
                            busy_d     = 1'b0;
                            in_ready_d = 1'b0;
                        end else begin
                            state_d = S_LOAD;
                            count_d = word[ADDR_W:0];
                        end
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    shift_d    = word[23:0];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        im_we_d    = 1'b1;
                        im_addr_d  = word_idx_q[ADDR_W-1:0];
                        im_wdata_d = word;
                        word_idx_d = next_idx;
                        // The final write and done leave on the same edge; cpu_rst follows a cycle later.
                        if (next_idx == count_q) begin
                            state_d    = S_DONE;
                            done_d     = 1'b1;
                            busy_d     = 1'b0;
                            in_ready_d = 1'b0;
                        end
                    end
                end
            end
            S_IDLE, S_DONE: cpu_rst_d = 1'b0;
            S_ERR:          ;
            default:        state_d = S_IDLE;
        endcase

        if (bus.start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR)) begin
            state_d    = S_HDR;
            done_d     = 1'b0;
            err_d      = 1'b0;
            byte_cnt_d = 2'd0;
            word_idx_d = '0;
            cpu_rst_d  = 1'b1;
            busy_d     = 1'b1;
            in_ready_d = 1'b1;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            count_q    <= '0;
            shift_q    <= '0;
            in_ready_q <= 1'b0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
            cpu_rst_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            in_ready_q <= in_ready_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
            cpu_rst_q  <= cpu_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.im_we    = im_we_q;
    assign bus.im_addr  = im_addr_q;
    assign bus.im_wdata = im_wdata_q;
    assign bus.cpu_rst  = cpu_rst_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader (ADDR_W=4, DEPTH=16).
// Expected writes and outcome come from decoding the byte stream directly.
module tb_imem_loader;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [7:0] byte_q_t [$];
    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
        logic        done;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    wr_t  wr_q [$];

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();
    imem_loader #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (bus.im_we === 1'b1)
            wr_q.push_back('{int'(bus.im_addr), bus.im_wdata, cyc, bus.done});

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        check({tag, "_im_we"},    64'(bus.im_we),    64'd0);
        check({tag, "_im_addr"},  64'(bus.im_addr),  64'd0);
        check({tag, "_im_wdata"}, 64'(bus.im_wdata), 64'd0);
        check({tag, "_busy"},     64'(bus.busy),     64'd0);
        check({tag, "_done"},     64'(bus.done),     64'd0);
        check({tag, "_err"},      64'(bus.err),      64'd0);
        check({tag, "_cpu_rst"},  64'(bus.cpu_rst),  64'd1);
    endtask

    function automatic byte_q_t make_stream(input logic [31:0] n, input int words);
        byte_q_t q;
        logic [31:0] d;
        q = '{n[31:24], n[23:16], n[15:8], n[7:0]};
        for (int w = 0; w < words; w++) begin
            d = $urandom;
            q.push_back(d[31:24]);
            q.push_back(d[23:16]);
            q.push_back(d[15:8]);
            q.push_back(d[7:0]);
        end
        return q;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        ok = 1'b0;
        repeat (gap) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int i = 0; i < 50; i++) begin
            if (bus.in_ready === 1'b1) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic start_load(input bit collide, input logic [7:0] first);
        @(negedge clk);
        bus.start = 1'b1;
        if (collide) begin
            bus.in_valid = 1'b1;
            bus.in_data  = first;
        end
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        check("start_in_ready", 64'(bus.in_ready), 64'd1);
        check("start_busy",     64'(bus.busy),     64'd1);
        check("start_cpu_rst",  64'(bus.cpu_rst),  64'd1);
        check("start_done",     64'(bus.done),     64'd0);
        check("start_err",      64'(bus.err),      64'd0);
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle between bytes, 2 random 0..3 idle cycles
    task automatic run_load(input byte_q_t stream, input int gap_mode, input bit collide);
        logic [31:0] n;
        bit          exp_err;
        int          exp_writes, consume, gap;
        bit          ok;
        logic [31:0] exp_data;

        n          = {stream[0], stream[1], stream[2], stream[3]};
        exp_err    = (n > 32'(DEPTH));
        exp_writes = exp_err ? 0 : int'(n);
        consume    = 4 + 4 * exp_writes;

        wr_q.delete();
        start_load(collide, stream[0]);
        for (int i = 0; i < consume; i++) begin
            gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 3));
            send_byte(stream[i], gap, ok);
            if (!ok) return;
        end

        @(negedge clk);
        check("end_done",     64'(bus.done),     64'(!exp_err));
        check("end_err",      64'(bus.err),      64'(exp_err));
        check("end_in_ready", 64'(bus.in_ready), 64'd0);
        check("end_busy",     64'(bus.busy),     64'd0);
        check("end_cpu_rst",  64'(bus.cpu_rst),  64'd1);
        check("end_im_we",    64'(bus.im_we),    64'(exp_writes > 0));
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        @(negedge clk);
        check("post_cpu_rst", 64'(bus.cpu_rst), 64'(exp_err));
        repeat (6) @(negedge clk);
        bus.in_valid = 1'b0;
        check("hold_in_ready", 64'(bus.in_ready), 64'd0);
        check("hold_done",     64'(bus.done),     64'(!exp_err));

        check("write_count", 64'(wr_q.size()), 64'(exp_writes));
        for (int w = 0; w < wr_q.size() && w < exp_writes; w++) begin
            exp_data = {stream[4+4*w], stream[5+4*w], stream[6+4*w], stream[7+4*w]};
            check("write_addr", 64'(wr_q[w].addr), 64'(w));
            check("write_data", 64'(wr_q[w].data), 64'(exp_data));
            check("write_done_flag", 64'(wr_q[w].done), 64'(w == exp_writes - 1));
            if (w > 0) begin
                if (gap_mode == 0)
                    check("write_spacing", 64'(wr_q[w].cyc - wr_q[w-1].cyc), 64'd4);
                else
                    check("write_spacing_min", 64'(wr_q[w].cyc - wr_q[w-1].cyc >= 4), 64'd1);
            end
        end
    endtask

    task automatic mid_load_reset(input byte_q_t stream);
        bit ok;
        wr_q.delete();
        start_load(1'b0, stream[0]);
        for (int i = 0; i < 6; i++) begin
            send_byte(stream[i], 0, ok);
            if (!ok) return;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        repeat (2) @(negedge clk);
        check("midrst_hold_cpu_rst", 64'(bus.cpu_rst), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_rel_cpu_rst",  64'(bus.cpu_rst),  64'd0);
        check("midrst_rel_in_ready", 64'(bus.in_ready), 64'd0);
        check("midrst_no_write",     64'(wr_q.size()),  64'd0);
    endtask

    initial begin
        byte_q_t spec_stream;
        byte_q_t s;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #1;
        check_reset_values("reset");
        repeat (3) @(negedge clk);
        check("reset_hold_cpu_rst", 64'(bus.cpu_rst), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("release_cpu_rst",  64'(bus.cpu_rst),  64'd0);
        check("release_in_ready", 64'(bus.in_ready), 64'd0);
        check("release_busy",     64'(bus.busy),     64'd0);

        spec_stream = '{8'h00, 8'h00, 8'h00, 8'h02,
                        8'h20, 8'h01, 8'h00, 8'h05,
                        8'h20, 8'h02, 8'h00, 8'h0A};
        run_load(spec_stream, 0, 1'b0);
        run_load(spec_stream, 1, 1'b1);

        s = make_stream(32'd0, 0);
        run_load(s, 2, 1'b0);

        s = make_stream(32'd17, 0);
        run_load(s, 0, 1'b0);
        s = make_stream(32'd3, 3);
        run_load(s, 2, 1'b0);

        s = make_stream(32'h0001_0000, 0);
        run_load(s, 2, 1'b0);

        mid_load_reset(spec_stream);
        run_load(spec_stream, 0, 1'b0);

        s = make_stream(32'(DEPTH), DEPTH);
        run_load(s, 2, 1'b0);

        for (int k = 0; k < 4; k++) begin
            int n;
            n = int'($urandom_range(1, DEPTH));
            s = make_stream(32'(n), n);
            run_load(s, 2, k[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Hardware program loader for the MIPS core's instruction memory. It accepts a byte stream on a valid/ready handshake and assembles big-endian 32-bit words, so the first byte received becomes bits 31:24. It writes the words to the instruction memory write port at word addresses 0..N-1 and holds the CPU in reset while loading. It is the writer for the instruction memory, replacing simulation-only preload with a synthesizable path.

## Interface
- ADDR_W, 10, instruction-memory word-address width; DEPTH = 2^ADDR_W words
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a load; honoured only in IDLE, DONE, ERR
- in_valid  in  1  byte available on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte; transfer = in_valid & in_ready at a rising edge
- im_we  out  1  instruction-memory write strobe, one cycle per word
- im_addr  out  ADDR_W  word address for the write
- im_wdata  out  32  word to write
- cpu_rst  out  1  reset to the CPU; high while loading or in error
- busy  out  1  high in HDR and LOAD
- done  out  1  load completed
- err  out  1  header word count exceeded DEPTH

## Operation
- States: IDLE, HDR, LOAD, DONE, ERR. All outputs are registered.
- Reset values: state IDLE, in_ready 0, im_we 0, im_addr 0, im_wdata 0, busy 0, done 0, err 0, cpu_rst 1.
- In IDLE, cpu_rst drops to 0 at the first edge after rst is released, so the CPU runs whatever the memory already holds.
- Transitions:
  - IDLE/DONE/ERR + start -> HDR. Clears done, err, byte counter and word counter. Sets cpu_rst 1, busy 1, in_ready 1.
  - HDR: accept 4 bytes to form the 32-bit count N.
  - N == 0 -> DONE.
  - N > DEPTH (any bit above bit ADDR_W set, or N == DEPTH+1..) -> ERR.
  - Otherwise -> LOAD.
  - LOAD: each group of 4 accepted bytes forms one word. The next cycle has im_we=1, im_addr=word index and im_wdata=word; the word index then increments.
  - When the Nth word completes, go to DONE.
- Byte counter is 2 bits and wraps 3->0 on each word. Word index is ADDR_W+1 bits wide; it never exceeds N.
- in_ready is 1 only in HDR and LOAD. In the other states, in_valid is ignored and the byte is not consumed.
- start is ignored in HDR and LOAD.
- DONE: done=1, busy=0, in_ready=0. cpu_rst falls one cycle after done rises, so the last write lands before the CPU fetches.
- ERR: err=1, cpu_rst stays 1, in_ready=0, no writes. Leave ERR only via start or rst.
- rst during a load returns immediately to reset values. Words already written stay in memory; no further im_we.

## Timing
- Let E be the edge accepting the 4th byte of a word. im_we is high in the cycle after E, for exactly one cycle.
- For the last word, state=DONE and done=1 also take effect at edge E. cpu_rst=0 takes effect at E+1.
- For the header, let E be the edge accepting its 4th byte. The state for HDR->LOAD/DONE/ERR takes effect at E.
- A byte can be accepted every cycle. Maximum throughput is one word per 4 cycles, with im_we pulses at least 4 cycles apart.
- Stalls (in_valid low) only delay assembly; partial words are held indefinitely.
- If start and in_valid are both asserted in IDLE, no byte is accepted that cycle; the first byte can be taken in the next cycle.

## Test plan
- Reset -> all outputs at reset values and cpu_rst=1 while rst is high. One cycle after release: cpu_rst=0, in_ready=0.
- start, then bytes 00 00 00 02 20 01 00 05 20 02 00 0A back-to-back:
  - im_we pulses with addr 0 / 20010005, then addr 1 / 2002000A, 4 cycles apart.
  - done=1 with the second pulse; cpu_rst=0 one cycle later.
- Same stream with in_valid low on alternate cycles -> identical writes and data; only timing stretches; no extra im_we.
- Header 00 00 00 00 -> DONE at the 4th header byte, no im_we, done=1.
- ADDR_W=4, header 00 00 00 11 (N=17) -> ERR: err=1, cpu_rst=1, in_ready=0. A new start followed by a valid stream then completes normally with err=0.
- rst pulsed after 6 bytes of a 2-word load -> reset values at once, no im_we. A following full load writes addr 0 and addr 1 correctly.
